// File: rtl/aplic_msi_writer.sv
// APLIC MSI writer: queues (hart, EIID) requests and issues each one as a single-beat
// AXI4 write to the target hart's IMSIC doorbell, with one write outstanding at a time.
module aplic_msi_writer #(
  parameter int unsigned      NrHarts        = 4,
  parameter int unsigned      EiidW          = 11,
  parameter int unsigned      AddrW          = 64,
  parameter int unsigned      DataW          = 64,
  parameter int unsigned      IdW            = 4,
  parameter logic [IdW-1:0]   AxiId          = '0,
  parameter logic [AddrW-1:0] MsiBaseAddr    = AddrW'(64'h2400_0000),
  parameter int unsigned      HartStrideLog2 = 12,
  parameter int unsigned      FifoDepth      = 4,
  localparam int unsigned     HartIdxW       = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic                i_clk,
  input  logic                ni_rst,
  input  logic                i_msi_valid,
  output logic                o_msi_ready,
  input  logic [HartIdxW-1:0] i_msi_hart,
  input  logic [EiidW-1:0]    i_msi_eiid,
  output logic                o_aw_valid,
  input  logic                i_aw_ready,
  output logic [AddrW-1:0]    o_aw_addr,
  output logic [IdW-1:0]      o_aw_id,
  output logic [7:0]          o_aw_len,
  output logic [2:0]          o_aw_size,
  output logic [1:0]          o_aw_burst,
  output logic                o_w_valid,
  input  logic                i_w_ready,
  output logic [DataW-1:0]    o_w_data,
  output logic [DataW/8-1:0]  o_w_strb,
  output logic                o_w_last,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [1:0]          i_b_resp,
  output logic                o_busy,
  output logic                o_err,
  output logic [15:0]         o_err_cnt
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned EntW = HartIdxW + EiidW;
  localparam logic [HartIdxW:0] NrHartsW = (HartIdxW + 1)'(NrHarts);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  state_e            state_q, state_d;
  logic [EntW-1:0]   fifo_q [FifoDepth];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full;
  logic              in_accept, in_err, push, pop, b_err;
  logic [EntW-1:0]   head;
  logic [AddrW-1:0]  aw_addr_q;
  logic [DataW-1:0]  w_data_q;
  logic              aw_valid_q, w_valid_q;
  logic              err_q;
  logic [15:0]       err_cnt_q;
  logic [16:0]       err_sum;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign o_msi_ready = !fifo_full;
  assign in_accept   = i_msi_valid && o_msi_ready;
  // A zero EIID is silently dropped, even when the hart index is also out of range.
  assign in_err      = in_accept && (i_msi_eiid != '0) && ({1'b0, i_msi_hart} >= NrHartsW);
  assign push        = in_accept && (i_msi_eiid != '0) && !in_err;
  assign head        = fifo_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      for (int unsigned i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q[PtrW-1:0]] <= {i_msi_hart, i_msi_eiid};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    b_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if ((!aw_valid_q || i_aw_ready) && (!w_valid_q || i_w_ready)) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (i_b_valid) begin
          state_d = IDLE;
          b_err   = (i_b_resp == 2'b10) || (i_b_resp == 2'b11);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
    end else if (pop) begin
      aw_valid_q <= 1'b1;
      w_valid_q  <= 1'b1;
      aw_addr_q  <= MsiBaseAddr + (AddrW'(head[EntW-1:EiidW]) << HartStrideLog2);
      w_data_q   <= DataW'(head[EiidW-1:0]);
    end else begin
      if (i_aw_ready) aw_valid_q <= 1'b0;
      if (i_w_ready)  w_valid_q  <= 1'b0;
    end
  end

  // Input-side and B-channel errors in one cycle merge into one pulse but count twice.
  assign err_sum = {1'b0, err_cnt_q} + 17'(in_err) + 17'(b_err);

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= in_err || b_err;
      err_cnt_q <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

  assign o_aw_valid = aw_valid_q;
  assign o_aw_addr  = aw_addr_q;
  assign o_aw_id    = AxiId;
  assign o_aw_len   = '0;
  assign o_aw_size  = 3'b010;
  assign o_aw_burst = 2'b01;
  assign o_w_valid  = w_valid_q;
  assign o_w_data   = w_data_q;
  assign o_w_strb   = (DataW / 8)'(4'hF);
  assign o_w_last   = 1'b1;
  assign o_b_ready  = (state_q == WAIT_B);
  assign o_busy     = !fifo_empty || (state_q != IDLE);
  assign o_err      = err_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_aplic_msi_writer.sv
// Bench for aplic_msi_writer: directed steps plus randomized requests against a queue model;
// an AXI slave responder with adjustable ready/response delays logs every handshake.
module tb_aplic_msi_writer;

  localparam int unsigned NR   = 5;   // non power of two so out-of-range harts are encodable
  localparam int unsigned HW   = 3;
  localparam int unsigned EW   = 11;
  localparam int unsigned FD   = 4;
  localparam logic [63:0] BASE = 64'h2400_0000;

  logic          i_clk = 1'b0;
  logic          ni_rst = 1'b0;
  logic          i_msi_valid = 1'b0;
  logic          o_msi_ready;
  logic [HW-1:0] i_msi_hart = '0;
  logic [EW-1:0] i_msi_eiid = '0;
  logic          o_aw_valid, i_aw_ready;
  logic [63:0]   o_aw_addr;
  logic [3:0]    o_aw_id;
  logic [7:0]    o_aw_len;
  logic [2:0]    o_aw_size;
  logic [1:0]    o_aw_burst;
  logic          o_w_valid, i_w_ready;
  logic [63:0]   o_w_data;
  logic [7:0]    o_w_strb;
  logic          o_w_last;
  logic          i_b_valid, o_b_ready;
  logic [1:0]    i_b_resp;
  logic          o_busy, o_err;
  logic [15:0]   o_err_cnt;

  always #5 i_clk = ~i_clk;

  aplic_msi_writer #(.NrHarts(NR), .FifoDepth(FD)) dut (
    .i_clk(i_clk), .ni_rst(ni_rst),
    .i_msi_valid(i_msi_valid), .o_msi_ready(o_msi_ready),
    .i_msi_hart(i_msi_hart), .i_msi_eiid(i_msi_eiid),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
    .o_aw_id(o_aw_id), .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
    .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
    .o_w_strb(o_w_strb), .o_w_last(o_w_last),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp),
    .o_busy(o_busy), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model: expected writes in order, responses to give them, expected error count
  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [1:0]  b_resp_q[$];
  int unsigned exp_err = 0;

  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [63:0] aw_log[$];
  logic [63:0] w_log[$];
  int unsigned stab_err = 0, fld_err = 0, extra_b = 0, b_hs = 0, err_cycles = 0;
  int unsigned cyc = 0, last_aw_cyc = 0, last_w_cyc = 0;
  int unsigned accepts = 0;
  int          first_stall = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave: inputs change only at negedge, so valid&&ready here is the next posedge handshake
  initial begin : bus
    int unsigned aw_cnt, w_cnt, b_cnt;
    bit aw_hold, w_hold, aw_done, w_done, b_pend;
    logic [63:0] aw_hold_addr, w_hold_data;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_hold = 0; w_hold = 0; aw_done = 0; w_done = 0; b_pend = 0;
    aw_hold_addr = '0; w_hold_data = '0;
    i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_resp = 2'b00;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!ni_rst) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_hold = 0; w_hold = 0; aw_done = 0; w_done = 0; b_pend = 0;
        i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_resp = 2'b00;
      end else begin
        if (o_err) err_cycles++;
        if (aw_hold && (!o_aw_valid || o_aw_addr !== aw_hold_addr)) stab_err++;
        if (w_hold && (!o_w_valid || o_w_data !== w_hold_data)) stab_err++;
        if (o_aw_valid) begin i_aw_ready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin i_aw_ready = 1'b0; aw_cnt = 0; end
        if (o_w_valid) begin i_w_ready = (w_cnt >= w_delay); w_cnt++; end
        else begin i_w_ready = 1'b0; w_cnt = 0; end
        aw_hold = o_aw_valid && !i_aw_ready; aw_hold_addr = o_aw_addr;
        w_hold  = o_w_valid && !i_w_ready;   w_hold_data  = o_w_data;
        if (o_aw_valid && i_aw_ready) begin
          aw_log.push_back(o_aw_addr); last_aw_cyc = cyc; aw_done = 1;
          if (o_aw_len !== 8'd0 || o_aw_size !== 3'b010 || o_aw_burst !== 2'b01 || o_aw_id !== 4'd0)
            fld_err++;
        end
        if (o_w_valid && i_w_ready) begin
          w_log.push_back(o_w_data); last_w_cyc = cyc; w_done = 1;
          if (o_w_strb !== 8'h0F || o_w_last !== 1'b1) fld_err++;
        end
        if (o_b_ready && !b_pend) extra_b++;
        if (b_pend) begin
          i_b_valid = (b_cnt >= b_delay); b_cnt++;
          i_b_resp = (b_resp_q.size() > 0) ? b_resp_q[0] : 2'b00;
          if (i_b_valid && o_b_ready) begin
            b_hs++;
            if (b_resp_q.size() > 0) void'(b_resp_q.pop_front());
            b_pend = 0; b_cnt = 0;
          end
        end else i_b_valid = 1'b0;
        if (aw_done && w_done) begin b_pend = 1; aw_done = 0; w_done = 0; end
      end
    end
  end

  // Called at a negedge; leaves i_msi_valid high one cycle after the accepting edge.
  task automatic send_msi(input logic [HW-1:0] hart, input logic [EW-1:0] eiid, input logic [1:0] resp);
    int unsigned n = 0;
    i_msi_valid = 1'b1; i_msi_hart = hart; i_msi_eiid = eiid;
    while (!o_msi_ready && n < 500) begin
      if (first_stall < 0) first_stall = int'(accepts);
      @(negedge i_clk); n++;
    end
    chk("accept_timeout", 64'(n >= 500), 0);
    accepts++;
    if (eiid != 0) begin
      if (hart >= NR) exp_err++;
      else begin
        exp_addr_q.push_back(BASE + (64'(hart) * 64'd4096));
        exp_data_q.push_back(64'(eiid));
        b_resp_q.push_back(resp);
        if (resp >= 2'b10) exp_err++;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (o_busy && n < budget) begin @(negedge i_clk); n++; end
    chk(tag, 64'(n >= budget), 0);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_writes(input string tag);
    int unsigned m;
    chk({tag, "_aw_count"}, 64'(aw_log.size()), 64'(exp_addr_q.size()));
    chk({tag, "_w_count"}, 64'(w_log.size()), 64'(exp_data_q.size()));
    m = (aw_log.size() < exp_addr_q.size()) ? aw_log.size() : exp_addr_q.size();
    for (int unsigned i = 0; i < m; i++) chk({tag, "_addr"}, aw_log[i], exp_addr_q[i]);
    m = (w_log.size() < exp_data_q.size()) ? w_log.size() : exp_data_q.size();
    for (int unsigned i = 0; i < m; i++) chk({tag, "_data"}, w_log[i], exp_data_q[i]);
    aw_log.delete(); w_log.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [HW-1:0] h;
    logic [EW-1:0] e;
    logic [1:0]    r;
    int unsigned   b0, e0, n;

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_msi_ready", o_msi_ready, 1);
    chk("rst_aw_valid", o_aw_valid, 0);
    chk("rst_w_valid", o_w_valid, 0);
    chk("rst_b_ready", o_b_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_aw_addr", o_aw_addr, 0);
    chk("rst_w_data", o_w_data, 0);
    ni_rst = 1'b1;
    @(negedge i_clk);

    // single MSI, latency and fields
    send_msi(3'd2, 11'd5, 2'b00);
    i_msi_valid = 1'b0;
    chk("lat_n1_aw_valid", o_aw_valid, 0);
    chk("lat_n1_busy", o_busy, 1);
    @(negedge i_clk);
    chk("lat_n2_aw_valid", o_aw_valid, 1);
    chk("lat_n2_w_valid", o_w_valid, 1);
    chk("single_addr", o_aw_addr, 64'h2400_2000);
    chk("single_wdata", o_w_data, 64'h5);
    chk("single_strb", o_w_strb, 8'h0F);
    chk("single_len", o_aw_len, 0);
    chk("single_size", o_aw_size, 3'b010);
    chk("single_burst", o_aw_burst, 2'b01);
    chk("single_last", o_w_last, 1);
    wait_idle("single_idle_timeout", 100);
    chk("single_busy", o_busy, 0);
    chk("single_err_cnt", o_err_cnt, 0);
    check_writes("single");

    // burst of 6 with AW stalled: one entry leaves to the FSM, so the FIFO fills after FD+1 accepts
    aw_delay = 20; accepts = 0; first_stall = -1;
    for (int i = 0; i < 6; i++)
      send_msi(HW'($urandom_range(0, NR - 1)), EW'($urandom_range(1, 2047)), 2'b00);
    i_msi_valid = 1'b0;
    chk("burst_stall_at", 64'(first_stall), 64'(FD + 1));
    wait_idle("burst_idle_timeout", 1000);
    check_writes("burst");
    aw_delay = 0;

    // AW delayed, W immediate
    aw_delay = 3; b0 = b_hs;
    send_msi(3'd4, 11'd1234, 2'b00);
    i_msi_valid = 1'b0;
    wait_idle("awdly_idle_timeout", 100);
    chk("awdly_w_first", 64'(last_w_cyc < last_aw_cyc), 1);
    chk("awdly_one_b", 64'(b_hs - b0), 1);
    chk("awdly_stable", 64'(stab_err), 0);
    check_writes("awdly");
    aw_delay = 0;

    // SLVERR then a normal queued request
    e0 = err_cycles;
    send_msi(3'd1, 11'd9, 2'b10);
    send_msi(3'd3, 11'd100, 2'b00);
    i_msi_valid = 1'b0;
    wait_idle("slverr_idle_timeout", 100);
    chk("slverr_pulse_cycles", 64'(err_cycles - e0), 1);
    chk("slverr_err_cnt", o_err_cnt, 64'(exp_err));
    check_writes("slverr");

    // zero EIID is dropped silently
    e0 = err_cycles;
    send_msi(3'd1, 11'd0, 2'b00);
    i_msi_valid = 1'b0;
    wait_idle("eiid0_idle_timeout", 100);
    chk("eiid0_no_err", 64'(err_cycles - e0), 0);
    check_writes("eiid0");

    // out-of-range hart
    e0 = err_cycles;
    send_msi(3'd7, 11'd33, 2'b00);
    i_msi_valid = 1'b0;
    chk("badhart_err_now", o_err, 1);
    wait_idle("badhart_idle_timeout", 100);
    chk("badhart_pulse_cycles", 64'(err_cycles - e0), 1);
    chk("badhart_err_cnt", o_err_cnt, 64'(exp_err));
    check_writes("badhart");

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 2);
      h = HW'($urandom_range(0, 7));
      e = ($urandom_range(0, 7) == 0) ? '0 : EW'($urandom_range(1, 2047));
      r = 2'($urandom_range(0, 3));
      send_msi(h, e, r);
      if ($urandom_range(0, 2) == 0) begin
        i_msi_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge i_clk);
      end
    end
    i_msi_valid = 1'b0;
    wait_idle("rand_idle_timeout", 3000);
    chk("rand_err_cnt", o_err_cnt, 64'(exp_err));
    check_writes("rand");
    aw_delay = 0; w_delay = 0;

    // reset while waiting for B with two requests queued
    b_delay = 40;
    send_msi(3'd0, 11'd11, 2'b00);
    send_msi(3'd1, 11'd22, 2'b00);
    send_msi(3'd2, 11'd33, 2'b00);
    i_msi_valid = 1'b0;
    n = 0;
    while (!o_b_ready && n < 100) begin @(negedge i_clk); n++; end
    chk("rst_mid_wait_timeout", 64'(n >= 100), 0);
    chk("rst_mid_busy_before", o_busy, 1);
    #2 ni_rst = 1'b0;
    #1;
    chk("rst_mid_aw_valid", o_aw_valid, 0);
    chk("rst_mid_w_valid", o_w_valid, 0);
    chk("rst_mid_b_ready", o_b_ready, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_msi_ready", o_msi_ready, 1);
    chk("rst_mid_err_cnt", o_err_cnt, 0);
    chk("rst_mid_aw_addr", o_aw_addr, 0);
    chk("rst_mid_w_data", o_w_data, 0);
    repeat (2) @(negedge i_clk);
    aw_log.delete(); w_log.delete(); exp_addr_q.delete(); exp_data_q.delete();
    b_resp_q.delete(); exp_err = 0; b_delay = 0;
    #2 ni_rst = 1'b1;
    repeat (20) @(negedge i_clk);
    chk("post_rst_no_aw", 64'(aw_log.size()), 0);
    chk("post_rst_busy", o_busy, 0);
    send_msi(3'd3, 11'd77, 2'b00);
    i_msi_valid = 1'b0;
    wait_idle("post_rst_idle_timeout", 100);
    chk("post_rst_err_cnt", o_err_cnt, 64'(exp_err));
    check_writes("post_rst");

    chk("payload_stability", 64'(stab_err), 0);
    chk("constant_fields", 64'(fld_err), 0);
    chk("b_ready_outside_wait", 64'(extra_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
